mix_column_sequencer: RTL and testbench

- Sequences one shared multi-cycle GF(2^8) multiplier to compute AES MixColumns or InvMixColumns on a single 32-bit state column.
- Sits between the round controller and the GF multiplier: accepts a column plus a mode bit, issues up to 16 byte multiplications, XOR-accumulates each output byte and returns the transformed column.
- Trades throughput for area; one multiplier instance serves the whole transform.

---
 rtl/aes_pkg.sv | 30 +++
 rtl/mc_coef_rom.sv | 18 +
 rtl/mix_column_sequencer.sv | 149 ++++++++++++++
 tb/tb_mix_column_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES MixColumns constants, FSM encoding and byte helpers.
// Imported by mc_coef_rom and mix_column_sequencer.
package aes_pkg;

   // Circulant row generators: K[0] occupies [31:24] ... K[3] occupies [7:0].
   localparam logic [31:0] K_FWD = 32'h0203_0101;
   localparam logic [31:0] K_INV = 32'h0E0B_0D09;

   localparam int unsigned BYTE_W = 8;
   localparam logic [1:0] ROW_FIRST = 2'd0;
   localparam logic [1:0] ROW_LAST = 2'd3;
   localparam logic [1:0] COL_LAST = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BYP,
      S_ISSUE,
      S_WAIT,
      S_OUT
   } state_t;

   // Byte idx of a column word; idx 0 is the most significant byte.
   function automatic logic [7:0] col_byte(
      input logic [31:0] col,
      input logic [1:0] idx
   );
      return col[{~idx, 3'b000} +: BYTE_W];
   endfunction

endpackage

// File: rtl/mc_coef_rom.sv
// Combinational MixColumns / InvMixColumns matrix coefficient lookup.
// Ports: inv (mode), r (row), c (column) -> coef (matrix byte M[r][c]).
module mc_coef_rom
   import aes_pkg::*;
(
   input  logic       inv,
   input  logic [1:0] r,
   input  logic [1:0] c,
   output logic [7:0] coef
);

   logic [1:0] k;

   // Circulant: M[r][c] = K[(c - r) mod 4]; 2-bit subtraction wraps.
   assign k = c - r;
   assign coef = inv ? col_byte(K_INV, k) : col_byte(K_FWD, k);

endmodule

// File: rtl/mix_column_sequencer.sv
// Computes (Inv)MixColumns on one column using a single external GF(2^8)
// multiplier. Ports: i_valid/o_ready/i_inv/i_column request side,
// o_valid/i_out_ready/o_column result side, gf_* multiplier start/done link.
module mix_column_sequencer
   import aes_pkg::*;
#(
   parameter bit SKIP_UNITY = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic        i_inv,
   input  logic [31:0] i_column,
   output logic        o_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_column,
   output logic        gf_start,
   output logic [7:0]  gf_a,
   output logic [7:0]  gf_b,
   input  logic [7:0]  gf_result,
   input  logic        gf_done
);

   state_t state;
   state_t state_nx;
   state_t sel_st;

   logic [31:0] col_q;
   logic [31:0] res_q;
   logic        inv_q;
   logic [1:0]  r_q;
   logic [1:0]  c_q;
   logic [7:0]  acc_q;
   logic [7:0]  ga_q;
   logic [7:0]  gb_q;

   logic       accept;
   logic       advance;
   logic       last_c;
   logic       last_r;
   logic [1:0] r_nx;
   logic [1:0] c_nx;
   logic       inv_nx;
   logic [7:0] coef_nx;
   logic [7:0] a_nx;
   logic [7:0] prod;
   logic [7:0] acc_x;

   assign accept = i_valid && (state == S_IDLE);
   assign advance = (state == S_BYP) ||
                    ((state == S_WAIT) && gf_done);
   assign last_c = (c_q == COL_LAST);
   assign last_r = (r_q == ROW_LAST);
   assign prod = (state == S_BYP) ? col_byte(col_q, c_q) : gf_result;
   assign acc_x = acc_q ^ prod;

   // Position of the product that follows this cycle; the coefficient of
   // that position decides bypass vs. issue without spending a cycle.
   always_comb begin
      inv_nx = inv_q;
      r_nx = r_q;
      c_nx = c_q + 2'd1;
      if (accept) begin
         inv_nx = i_inv;
         r_nx = ROW_FIRST;
         c_nx = 2'd0;
      end else if (last_c) begin
         r_nx = r_q + 2'd1;
         c_nx = 2'd0;
      end
   end

   assign a_nx = accept ? col_byte(i_column, 2'd0) : col_byte(col_q, c_nx);

   mc_coef_rom u_rom (
      .inv  (inv_nx),
      .r    (r_nx),
      .c    (c_nx),
      .coef (coef_nx)
   );

   assign sel_st = (SKIP_UNITY && (coef_nx == 8'h01)) ? S_BYP : S_ISSUE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (i_valid) state_nx = sel_st;
         S_BYP: state_nx = (last_c && last_r) ? S_OUT : sel_st;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT: begin
            if (gf_done) state_nx = (last_c && last_r) ? S_OUT : sel_st;
         end
         S_OUT: if (i_out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state == S_IDLE);
      o_valid = (state == S_OUT);
      gf_start = (state == S_ISSUE);
      o_column = res_q;
      gf_a = ga_q;
      gf_b = gb_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         res_q <= '0;
         inv_q <= 1'b0;
         r_q <= '0;
         c_q <= '0;
         acc_q <= '0;
         ga_q <= '0;
         gb_q <= '0;
      end else begin
         if (accept) begin
            col_q <= i_column;
            inv_q <= i_inv;
            r_q <= ROW_FIRST;
            c_q <= 2'd0;
            acc_q <= '0;
         end else if (advance) begin
            if (last_c) begin
               res_q[{~r_q, 3'b000} +: BYTE_W] <= acc_x;
               acc_q <= '0;
               r_q <= r_q + 2'd1;
               c_q <= 2'd0;
            end else begin
               acc_q <= acc_x;
               c_q <= c_q + 2'd1;
            end
         end
         // Operands are captured on entry to ISSUE and held through WAIT.
         if (state_nx == S_ISSUE) begin
            ga_q <= a_nx;
            gb_q <= coef_nx;
         end
      end
   end

endmodule

// File: tb/tb_mix_column_sequencer.sv
// Self-checking bench: two sequencers (bypass on / off) each driving a
// behavioural GF(2^8) multiplier with start-to-done delay N.
module tb_mix_column_sequencer;

   localparam int N = 8;

   logic clk = 1'b0;
   logic rst_n;

   logic [1:0] iv;
   logic [1:0] ordy;
   logic [1:0] inv_v;
   logic [1:0] ovld;
   logic [1:0] out_rdy;
   logic [1:0] gs;
   logic [1:0] gd;
   logic [1:0] spur;
   logic [31:0] icol [2];
   logic [31:0] ocol [2];
   logic [7:0] ga [2];
   logic [7:0] gb [2];
   logic [7:0] gr [2];

   logic busy [2] = '{1'b0, 1'b0};
   int cnt [2] = '{0, 0};
   logic [7:0] mres [2] = '{8'h00, 8'h00};
   int starts [2] = '{0, 0};
   int cyc = 0;

   int tests = 0;
   int fails = 0;
   int t0;
   int s0;
   logic [31:0] sb [$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      end
      return p;
   endfunction

   // Multiplier model: done is high in the Nth cycle after start was sampled.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (gs[k]) begin
            busy[k] <= 1'b1;
            cnt[k] <= N - 1;
            mres[k] <= gmul(ga[k], gb[k]);
            starts[k] <= starts[k] + 1;
         end else if (busy[k]) begin
            if (cnt[k] == 0) busy[k] <= 1'b0;
            else cnt[k] <= cnt[k] - 1;
         end
      end
   end

   assign gd[0] = (busy[0] && cnt[0] == 0) || spur[0];
   assign gd[1] = (busy[1] && cnt[1] == 0) || spur[1];
   assign gr[0] = spur[0] ? 8'hA5 : mres[0];
   assign gr[1] = spur[1] ? 8'hA5 : mres[1];

   mix_column_sequencer #(.SKIP_UNITY(1'b1)) u0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (iv[0]),
      .o_ready     (ordy[0]),
      .i_inv       (inv_v[0]),
      .i_column    (icol[0]),
      .o_valid     (ovld[0]),
      .i_out_ready (out_rdy[0]),
      .o_column    (ocol[0]),
      .gf_start    (gs[0]),
      .gf_a        (ga[0]),
      .gf_b        (gb[0]),
      .gf_result   (gr[0]),
      .gf_done     (gd[0])
   );

   mix_column_sequencer #(.SKIP_UNITY(1'b0)) u1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (iv[1]),
      .o_ready     (ordy[1]),
      .i_inv       (inv_v[1]),
      .i_column    (icol[1]),
      .o_valid     (ovld[1]),
      .i_out_ready (out_rdy[1]),
      .o_column    (ocol[1]),
      .gf_start    (gs[1]),
      .gf_a        (ga[1]),
      .gf_b        (gb[1]),
      .gf_result   (gr[1]),
      .gf_done     (gd[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input int s, input logic [31:0] col, input logic inv,
                       input logic [31:0] exp);
      @(negedge clk);
      chk("ready_before_accept", 32'(ordy[s]), 32'd1);
      iv[s] = 1'b1;
      icol[s] = col;
      inv_v[s] = inv;
      sb.push_back(exp);
      s0 = starts[s];
      @(posedge clk);
      @(negedge clk);
      iv[s] = 1'b0;
      t0 = cyc;
      chk("ready_drops", 32'(ordy[s]), 32'd0);
   endtask

   task automatic recv(input int s, input int lat_exp, input int st_exp,
                       input int stall, input string tag);
      int n;
      logic [31:0] exp;
      logic [31:0] hold;
      n = 0;
      while (!ovld[s] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid_seen"}, 32'(ovld[s]), 32'd1);
      chk({tag, "_latency"}, 32'(cyc - t0), 32'(lat_exp));
      chk({tag, "_starts"}, 32'(starts[s] - s0), 32'(st_exp));
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk({tag, "_column"}, ocol[s], exp);
      hold = ocol[s];
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, "_stall_col"}, ocol[s], hold);
         chk({tag, "_stall_valid"}, 32'(ovld[s]), 32'd1);
         chk({tag, "_stall_ready"}, 32'(ordy[s]), 32'd0);
      end
      out_rdy[s] = 1'b1;
      @(negedge clk);
      out_rdy[s] = 1'b0;
      chk({tag, "_ready_after"}, 32'(ordy[s]), 32'd1);
      chk({tag, "_valid_clear"}, 32'(ovld[s]), 32'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      iv = '0;
      inv_v = '0;
      out_rdy = '0;
      spur = '0;
      icol[0] = '0;
      icol[1] = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ordy[0]), 32'd1);
      chk("rst_valid", 32'(ovld[0]), 32'd0);
      chk("rst_column", ocol[0], 32'h0);
      chk("rst_start", 32'(gs[0]), 32'd0);
      chk("rst_gf_ab", {16'h0, ga[0], gb[0]}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Forward with bypass; a spurious done lands while in BYP of row 0.
      send(0, 32'hDB135345, 1'b0, 32'h8E4DA1BC);
      while (cyc < t0 + 18) @(negedge clk);
      spur[0] = 1'b1;
      @(negedge clk);
      spur[0] = 1'b0;
      recv(0, 8 * (N + 1) + 8, 8, 0, "fwd_db");

      send(0, 32'h8E4DA1BC, 1'b1, 32'hDB135345);
      recv(0, 16 * (N + 1), 16, 0, "inv_8e");

      // Stalled result followed by a back-to-back request.
      send(0, 32'hF20A225C, 1'b0, 32'h9FDC589D);
      recv(0, 80, 8, 5, "fwd_f2_stall");
      send(0, 32'hC6C6C6C6, 1'b0, 32'hC6C6C6C6);
      recv(0, 80, 8, 0, "fwd_c6");

      // No bypass: every coefficient goes through the multiplier.
      spur[1] = 1'b1;
      @(negedge clk);
      spur[1] = 1'b0;
      chk("idle_spur_ready", 32'(ordy[1]), 32'd1);
      chk("idle_spur_valid", 32'(ovld[1]), 32'd0);
      send(1, 32'h01010101, 1'b0, 32'h01010101);
      recv(1, 144, 16, 0, "noskip_01");
      spur[1] = 1'b1;
      @(negedge clk);
      spur[1] = 1'b0;
      @(negedge clk);
      chk("idle_spur2_valid", 32'(ovld[1]), 32'd0);

      // Reset during the row-2 multiply wait.
      send(0, 32'hDB135345, 1'b0, 32'h8E4DA1BC);
      while (cyc < t0 + 45) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_ready", 32'(ordy[0]), 32'd1);
      chk("abort_valid", 32'(ovld[0]), 32'd0);
      chk("abort_column", ocol[0], 32'h0);
      chk("abort_start", 32'(gs[0]), 32'd0);
      chk("abort_gf_ab", {16'h0, ga[0], gb[0]}, 32'h0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("late_done_valid", 32'(ovld[0]), 32'd0);
      chk("late_done_ready", 32'(ordy[0]), 32'd1);
      send(0, 32'hD4D4D4D5, 1'b0, 32'hD5D5D7D6);
      recv(0, 80, 8, 0, "post_rst_d4");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
